reg_file_wb: RTL
================

# reg_file_wb

Register file and write-back stage for the MIPS_Lite 8-bit datapath. It stores the eight 8-bit architectural registers. It supplies Rs_data and Rt_data to the execute stage, where Rt_data feeds the ALU operand-source mux. It accepts the write-back result, selected between ALU result and memory data, on the return path. Same-cycle write-to-read forwarding lets a dependent instruction see the value being written.

## Interface
Parameters:
- DATA_W, 8, register and data width
- ADDR_W, 3, register address width (2**ADDR_W registers)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- Rs_addr  input  ADDR_W  read port A address
- Rt_addr  input  ADDR_W  read port B address
- Rs_data  output  DATA_W  read port A data (combinational)
- Rt_data  output  DATA_W  read port B data (combinational)
- Wr_addr  input  ADDR_W  write-back destination register
- ALU_result  input  DATA_W  write-back candidate from ALU
- Mem_data  input  DATA_W  write-back candidate from data memory
- MemtoReg_cntrl  input  1  0 selects ALU_result, 1 selects Mem_data
- RegWrite_cntrl  input  1  write enable for this cycle
- Wb_data  output  DATA_W  selected write-back value (combinational, for debug/forwarding)
- Wr_count  output  8  number of committed writes since reset, saturating at 255

## Operation
- Wb_data = MemtoReg_cntrl ? Mem_data : ALU_result. Wb_data follows its inputs regardless of RegWrite_cntrl.
- Write commit:
  - On a rising clk edge with RegWrite_cntrl=1 and Wr_addr!=0, reg[Wr_addr] <= Wb_data.
  - Wr_count increments by 1 unless it is already 255.
  - A write with Wr_addr=0 is discarded: no register change, no count.
- Register 0:
  - Reads as 0 always.
  - Storage for register 0 is never written.
- Reads are combinational from the storage array.
- Forwarding rule, applied per read port independently:
  - Condition: RegWrite_cntrl=1, Wr_addr!=0 and read address == Wr_addr.
  - When the condition holds, the port returns Wb_data, not the stored value.
  - Both ports forward if both addresses match.
- Arithmetic: no arithmetic on data. Wr_count is an 8-bit saturating counter; it does not wrap.
- Reset:
  - rst=1 immediately clears all registers and Wr_count to 0, independent of clk.
  - A write presented during reset is lost.
  - Reset deasserting mid-stream leaves the first post-reset edge as a normal write edge.

## Timing
- Reset values:
  - Rs_data, Rt_data = 0 unless forwarding is active. If it is, they equal Wb_data, since forwarding is combinational and stays active during reset.
  - Wr_count = 0.
  - Wb_data is combinational, never reset.
- Write latency: 1 edge. The value is stored at edge N. Without forwarding it is visible on read ports after edge N, and combinationally before edge N via forwarding.
- Read latency: 0 cycles (combinational address-to-data).
- Back-to-back writes to the same register on consecutive cycles: the last write wins. Reads in each cycle see that cycle's pending Wb_data.
- Write and read of different registers in the same cycle: the read returns the old stored value of its own register, unaffected.
- RegWrite_cntrl=0: no state change, no forwarding. Wb_data still reflects the mux.

## Test plan
- Reset then read: assert rst, read all 8 addresses on both ports -> every read 0, Wr_count=0.
- ALU write-back:
  - Stimulus: Wr_addr=3, ALU_result=8'd16, MemtoReg_cntrl=0, RegWrite_cntrl=1, one edge, then RegWrite_cntrl=0 and Rt_addr=3.
  - Response: Rt_data=16, Wr_count=1.
  - Then set Mem_data=8'd6, MemtoReg_cntrl=1, write to addr 5 -> Rs_addr=5 reads 6 and reg 3 still reads 16.
- Forwarding:
  - Stimulus: reg 2 holds 2; present RegWrite_cntrl=1, Wr_addr=2, ALU_result=8'd8, with Rs_addr=Rt_addr=2.
  - Response: before the edge both ports read 8. Drop RegWrite_cntrl after the edge -> both still read 8.
  - Also: RegWrite_cntrl=0 with the same inputs -> both ports read 2.
- Register 0:
  - Stimulus: write 8'hFF to Wr_addr=0.
  - Response: Rs_data/Rt_data at addr 0 are 0 before and after the edge, and Wr_count is unchanged.
- Saturation: perform 300 writes to addr 1 with incrementing data -> Wr_count stops at 255 and reg 1 = 300 mod 256 = 44 (last data written).
- Async reset mid-operation: fill regs 1-7 with 1..7, pulse rst between edges -> all reads 0 immediately, before any clk edge, and Wr_count=0.

Source files
------------

// File: rtl/reg_file_wb.sv
// Eight-entry register file with write-back mux, same-cycle write-to-read forwarding
// and a saturating count of committed writes.
module reg_file_wb #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] Rs_addr,
   input  logic [ADDR_W-1:0] Rt_addr,
   output logic [DATA_W-1:0] Rs_data,
   output logic [DATA_W-1:0] Rt_data,
   input  logic [ADDR_W-1:0] Wr_addr,
   input  logic [DATA_W-1:0] ALU_result,
   input  logic [DATA_W-1:0] Mem_data,
   input  logic              MemtoReg_cntrl,
   input  logic              RegWrite_cntrl,
   output logic [DATA_W-1:0] Wb_data,
   output logic [7:0]        Wr_count
);

   localparam int unsigned NumRegs = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs_q [NumRegs];
   logic [7:0]        wr_count_q;
   logic              wr_en;

   assign Wb_data = MemtoReg_cntrl ? Mem_data : ALU_result;

   // Writes to register 0 are dropped entirely, so its storage keeps its reset value.
   assign wr_en = RegWrite_cntrl && (Wr_addr != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(NumRegs); i++) begin
            regs_q[i] <= '0;
         end
         wr_count_q <= '0;
      end else if (wr_en) begin
         regs_q[Wr_addr] <= Wb_data;
         if (wr_count_q != 8'hFF) begin
            wr_count_q <= wr_count_q + 8'd1;
         end
      end
   end

   // Forwarding stays live during reset since it depends only on the current inputs.
   always_comb begin
      Rs_data = '0;
      Rt_data = '0;
      if (wr_en && (Rs_addr == Wr_addr)) begin
         Rs_data = Wb_data;
      end else if (Rs_addr != '0) begin
         Rs_data = regs_q[Rs_addr];
      end
      if (wr_en && (Rt_addr == Wr_addr)) begin
         Rt_data = Wb_data;
      end else if (Rt_addr != '0) begin
         Rt_data = regs_q[Rt_addr];
      end
   end

   assign Wr_count = wr_count_q;

endmodule
